// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter with a small transmit FIFO in front of the
// serialiser. A frame is start bit, DATA_BITS data bits sent LSB first, an
// optional even/odd parity bit, then STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT clocks. When another word is queued at the end of a frame,
// the next frame follows with no idle gap.
//
// Ports
//   i_Clock      : single clock, all logic on its rising edge
//   i_Rst_n      : synchronous active-low reset
//   i_Tx_DV      : write strobe for i_Tx_Byte
//   i_Tx_Byte    : data word to queue (DATA_BITS wide)
//   o_Tx_Ready   : FIFO can accept a word this cycle
//   o_Tx_Active  : a frame is in progress
//   o_Tx_Serial  : serial line, idle high
//   o_Tx_Done    : one-cycle pulse after the last stop-bit cycle
//   o_Fifo_Count : number of queued words
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    // Elaboration-time rejection of unsupported configurations
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [31:0]          r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_tx_serial;
    logic                 r_tx_done;
    logic                 r_tx_active;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_tx_ready;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t               w_state_nx;
    logic [31:0]          w_clk_cnt_nx;
    logic [IDX_W-1:0]     w_bit_idx_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_par_nx;
    logic                 w_serial_nx;
    logic                 w_done_nx;
    logic                 w_active_nx;
    logic                 w_pop;

    logic                 w_push;
    logic                 w_fifo_empty;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic [CNT_W-1:0]     w_count_nx;

    // FIFO status and head-of-queue view
    assign w_push       = i_Rst_n & i_Tx_DV & r_tx_ready;
    assign w_fifo_empty = (r_count == CNT_W'(0));
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_par   = (PARITY == 2) ? ~^w_head : ^w_head;
    assign w_bit_end    = (r_clk_cnt == 32'(CLKS_PER_BIT - 1));

    // ------------------------------------------------------------------
    // FSM next-state and output logic. The serial line is registered,
    // so the value computed here is the one the line shows next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_clk_cnt_nx = r_clk_cnt;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_par_nx     = r_par_bit;
        w_serial_nx  = r_tx_serial;
        w_done_nx    = 1'b0;
        w_active_nx  = r_tx_active;
        w_pop        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_serial_nx  = 1'b1;
                w_active_nx  = 1'b0;
                w_clk_cnt_nx = 32'd0;
                w_bit_idx_nx = IDX_W'(0);
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nx  = S_START;
                    w_serial_nx = 1'b0;
                    w_active_nx = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nx = 32'd0;
                    w_bit_idx_nx = IDX_W'(0);
                    w_state_nx   = S_DATA;
                    w_serial_nx  = r_shift[0];
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 32'd1;
                end
            end

            // The shift register always presents the current bit at [0]
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nx = 32'd0;
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_bit_idx_nx = IDX_W'(0);
                        if (PARITY != 0) begin
                            w_state_nx  = S_PARITY;
                            w_serial_nx = r_par_bit;
                        end else begin
                            w_state_nx  = S_STOP;
                            w_serial_nx = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nx = r_bit_idx + IDX_W'(1);
                        w_shift_nx   = r_shift >> 1;
                        w_serial_nx  = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 32'd1;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_clk_cnt_nx = 32'd0;
                    w_bit_idx_nx = IDX_W'(0);
                    w_state_nx   = S_STOP;
                    w_serial_nx  = 1'b1;
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 32'd1;
                end
            end

            // Bit index counts stop bits; the last one may chain straight
            // into the next frame's start bit
            S_STOP: begin
                w_serial_nx = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_nx = 32'd0;
                    if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        w_done_nx    = 1'b1;
                        w_bit_idx_nx = IDX_W'(0);
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_state_nx  = S_START;
                            w_serial_nx = 1'b0;
                            w_active_nx = 1'b1;
                        end else begin
                            w_state_nx  = S_IDLE;
                            w_active_nx = 1'b0;
                        end
                    end else begin
                        w_bit_idx_nx = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 32'd1;
                end
            end

            default: begin
                w_state_nx   = S_IDLE;
                w_clk_cnt_nx = 32'd0;
                w_bit_idx_nx = IDX_W'(0);
                w_serial_nx  = 1'b1;
                w_active_nx  = 1'b0;
            end
        endcase

        // Load the head word and its parity whenever a frame starts
        if (w_pop) begin
            w_shift_nx = w_head;
            w_par_nx   = w_head_par;
        end
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        w_count_nx = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nx = r_count + CNT_W'(1);
            2'b01:   w_count_nx = r_count - CNT_W'(1);
            default: w_count_nx = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // State and FIFO control registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= 32'd0;
            r_bit_idx   <= IDX_W'(0);
            r_shift     <= DATA_BITS'(0);
            r_par_bit   <= 1'b0;
            r_tx_serial <= 1'b1;
            r_tx_done   <= 1'b0;
            r_tx_active <= 1'b0;
            r_wr_ptr    <= PTR_W'(0);
            r_rd_ptr    <= PTR_W'(0);
            r_count     <= CNT_W'(0);
            r_tx_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_clk_cnt   <= w_clk_cnt_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_shift     <= w_shift_nx;
            r_par_bit   <= w_par_nx;
            r_tx_serial <= w_serial_nx;
            r_tx_done   <= w_done_nx;
            r_tx_active <= w_active_nx;
            r_count     <= w_count_nx;
            r_tx_ready  <= (w_count_nx < CNT_W'(FIFO_DEPTH));
            // Pointers wrap naturally because FIFO_DEPTH is a power of two
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready   = r_tx_ready;
    assign o_Tx_Active  = r_tx_active;
    assign o_Tx_Serial  = r_tx_serial;
    assign o_Tx_Done    = r_tx_done;
    assign o_Fifo_Count = r_count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Four transmitter instances with CLKS_PER_BIT=4 and FIFO_DEPTH=4:
//   0: 8 data bits, no parity, 1 stop
//   1: 8 data bits, even parity, 1 stop
//   2: 8 data bits, odd parity, 1 stop
//   3: 5 data bits, no parity, 2 stop
// Words expected on the line are queued per instance when driven; a
// per-instance monitor rebuilds the expected per-cycle waveform of each frame
// from the queued word and compares it with the captured line.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int CPB  = 4;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_dv   [NDUT];
    logic [8:0] tx_byte [NDUT];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] exp_q   [NDUT][$];
    int         start_q [NDUT][$];
    int         done_q  [NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB = (g == 3) ? 5 : 8;
        localparam int P  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int SB = (g == 3) ? 2 : 1;
        localparam int NB = 1 + DB + ((P != 0) ? 1 : 0) + SB;
        localparam int FL = NB * CPB;

        logic       ser;
        logic       act;
        logic       done;
        logic       rdy;
        logic [2:0] cnt;

        uart_tx_cfg #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY       (P),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .i_Clock      (clk),
            .i_Rst_n      (rst_n),
            .i_Tx_DV      (tx_dv[g]),
            .i_Tx_Byte    (tx_byte[g][DB-1:0]),
            .o_Tx_Ready   (rdy),
            .o_Tx_Active  (act),
            .o_Tx_Serial  (ser),
            .o_Tx_Done    (done),
            .o_Fifo_Count (cnt)
        );

        bit          in_frame  = 1'b0;
        bit          pend_done = 1'b0;
        bit          act_ok;
        int          idx;
        logic [63:0] cap;
        logic [63:0] expv;
        logic [8:0]  w;
        logic        bv;

        // Frame monitor: starts on the first low cycle while not in a frame
        always @(negedge clk) begin
            if (!rst_n) begin
                in_frame  = 1'b0;
                pend_done = 1'b0;
            end else begin
                if (done) done_q[g].push_back(cyc);
                if (pend_done) begin
                    check($sformatf("done_after_frame_dut%0d", g), 64'(done), 64'd1);
                    pend_done = 1'b0;
                end
                if (!in_frame && (ser == 1'b0)) begin
                    start_q[g].push_back(cyc);
                    check($sformatf("frame_was_expected_dut%0d", g), 64'(exp_q[g].size() != 0), 64'd1);
                    w = (exp_q[g].size() != 0) ? exp_q[g].pop_front() : 9'd0;
                    expv = 64'd0;
                    for (int b = 0; b < NB; b++) begin
                        if (b == 0)                        bv = 1'b0;
                        else if (b <= DB)                  bv = w[b-1];
                        else if ((P != 0) && (b == DB+1))  bv = (P == 1) ? ^w[DB-1:0] : ~^w[DB-1:0];
                        else                               bv = 1'b1;
                        for (int c = 0; c < CPB; c++) expv[b*CPB + c] = bv;
                    end
                    in_frame = 1'b1;
                    idx      = 0;
                    cap      = 64'd0;
                    act_ok   = 1'b1;
                end
                if (in_frame) begin
                    cap[idx[5:0]] = ser;
                    if (!act) act_ok = 1'b0;
                    idx++;
                    if (idx == FL) begin
                        check($sformatf("frame_bits_dut%0d_word%0h", g, w), cap, expv);
                        check($sformatf("active_in_frame_dut%0d", g), 64'(act_ok), 64'd1);
                        in_frame  = 1'b0;
                        pend_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int k, input logic [8:0] w, input bit on_line);
        tx_dv[k]   = 1'b1;
        tx_byte[k] = w;
        if (on_line) exp_q[k].push_back(w);
        tick(1);
        tx_dv[k] = 1'b0;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            start_q[k].delete();
            done_q[k].delete();
        end
    endtask

    // Bounded wait for all expected words to reach the line, then let the
    // last frame and its done pulse complete
    task automatic drain(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q[k].size() == 0) break;
            tick(1);
        end
        check($sformatf("queue_drained_dut%0d", k), 64'(exp_q[k].size()), 64'd0);
        tick(70);
    endtask

    function automatic int first_or(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1000;
    endfunction

    int         n;
    logic [8:0] fw [5];

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            tx_dv[k]   = 1'b0;
            tx_byte[k] = 9'd0;
        end
        tick(2);

        // Writes during reset are ignored; reset values
        tx_dv[0]   = 1'b1;
        tx_byte[0] = 9'h033;
        tick(2);
        check("rst_serial", 64'(g_dut[0].ser), 64'd1);
        check("rst_done",   64'(g_dut[0].done), 64'd0);
        check("rst_active", 64'(g_dut[0].act), 64'd0);
        check("rst_count",  64'(g_dut[0].cnt), 64'd0);
        check("rst_ready",  64'(g_dut[0].rdy), 64'd1);
        tx_dv[0] = 1'b0;
        rst_n    = 1'b1;
        tick(12);
        check("post_rst_count",  64'(g_dut[0].cnt), 64'd0);
        check("post_rst_serial", 64'(g_dut[0].ser), 64'd1);
        check("post_rst_frames", 64'(start_q[0].size()), 64'd0);

        // 8N1, 0xA5
        clear_logs();
        n = cyc;
        push(0, 9'h0A5, 1'b1);
        drain(0, 200);
        check("a5_start_latency", 64'(first_or(start_q[0], 0) - n), 64'd2);
        check("a5_done_count",    64'(done_q[0].size()), 64'd1);
        check("a5_done_offset",   64'(first_or(done_q[0], 0) - first_or(start_q[0], 0)), 64'd40);
        check("a5_idle_active",   64'(g_dut[0].act), 64'd0);
        check("a5_idle_serial",   64'(g_dut[0].ser), 64'd1);

        // 8E1 and 8O1, 0x07
        clear_logs();
        push(1, 9'h007, 1'b1);
        drain(1, 200);
        check("even_done_count",  64'(done_q[1].size()), 64'd1);
        check("even_frame_len",   64'(first_or(done_q[1], 0) - first_or(start_q[1], 0)), 64'd44);
        push(2, 9'h007, 1'b1);
        drain(2, 200);
        check("odd_done_count",   64'(done_q[2].size()), 64'd1);
        check("odd_frame_len",    64'(first_or(done_q[2], 0) - first_or(start_q[2], 0)), 64'd44);

        // 5 data bits, 2 stop bits, 0x13
        push(3, 9'h013, 1'b1);
        drain(3, 200);
        check("db5_done_count",   64'(done_q[3].size()), 64'd1);
        check("db5_frame_len",    64'(first_or(done_q[3], 0) - first_or(start_q[3], 0)), 64'd32);

        // FIFO fill while a frame is active: fifth word must be dropped
        clear_logs();
        fw[0] = 9'h011; fw[1] = 9'h022; fw[2] = 9'h033; fw[3] = 9'h044; fw[4] = 9'h0EE;
        push(0, 9'h0C3, 1'b1);
        tick(3);
        check("fill_active", 64'(g_dut[0].act), 64'd1);
        tx_dv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_byte[0] = fw[i];
            if (i < 4) exp_q[0].push_back(fw[i]);
            tick(1);
            check($sformatf("fill_count_%0d", i), 64'(g_dut[0].cnt), 64'((i < 4) ? i + 1 : 4));
            check($sformatf("fill_ready_%0d", i), 64'(g_dut[0].rdy), 64'((i < 3) ? 1 : 0));
        end
        tx_dv[0] = 1'b0;
        drain(0, 400);
        check("fill_frames",     64'(start_q[0].size()), 64'd5);
        check("fill_done_count", 64'(done_q[0].size()), 64'd5);
        check("fill_end_count",  64'(g_dut[0].cnt), 64'd0);

        // Back-to-back frames: no gap, done pulses 40 apart
        clear_logs();
        push(0, 9'h055, 1'b1);
        push(0, 9'h00F, 1'b1);
        drain(0, 200);
        check("b2b_frames",     64'(start_q[0].size()), 64'd2);
        check("b2b_start_gap",  64'(first_or(start_q[0], 1) - first_or(start_q[0], 0)), 64'd40);
        check("b2b_done_count", 64'(done_q[0].size()), 64'd2);
        check("b2b_done_gap",   64'(first_or(done_q[0], 1) - first_or(done_q[0], 0)), 64'd40);

        // Reset during data bit 3 with words still queued
        clear_logs();
        n = cyc;
        push(0, 9'h096, 1'b1);
        push(0, 9'h03C, 1'b0);
        push(0, 9'h05A, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (cyc >= n + 19) break;
            tick(1);
        end
        check("midrst_count_before", 64'(g_dut[0].cnt), 64'd2);
        check("midrst_active_before", 64'(g_dut[0].act), 64'd1);
        rst_n = 1'b0;
        tick(1);
        check("midrst_serial", 64'(g_dut[0].ser), 64'd1);
        check("midrst_count",  64'(g_dut[0].cnt), 64'd0);
        check("midrst_active", 64'(g_dut[0].act), 64'd0);
        check("midrst_ready",  64'(g_dut[0].rdy), 64'd1);
        rst_n = 1'b1;
        tick(100);
        check("midrst_no_done",   64'(done_q[0].size()), 64'd0);
        check("midrst_no_resend", 64'(start_q[0].size()), 64'd1);
        check("midrst_idle_line", 64'(g_dut[0].ser), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- CLKS_PER_BIT, 87: i_Clock cycles per serial bit; legal range >= 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, >= 2.

REQ-002 Illegal parameter values SHALL cause an elaboration-time error.

REQ-003 The ports SHALL be, one per line as name, direction, width, meaning:
- i_Clock, input, 1: the single clock; all logic on its rising edge.
- i_Rst_n, input, 1: reset, synchronous, active-low.
- i_Tx_DV, input, 1: write strobe for i_Tx_Byte.
- i_Tx_Byte, input, DATA_BITS: data word to queue.
- o_Tx_Ready, output, 1: FIFO can accept a word this cycle.
- o_Tx_Active, output, 1: a frame is in progress.
- o_Tx_Serial, output, 1: serial line, idle high.
- o_Tx_Done, output, 1: one-cycle pulse at the end of each frame.
- o_Fifo_Count, output, $clog2(FIFO_DEPTH)+1: number of queued words.

REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-005 o_Tx_Ready SHALL equal (o_Fifo_Count < FIFO_DEPTH), derived from the registered count only.

REQ-006 A push SHALL occur only when i_Tx_DV=1 and o_Tx_Ready=1.
- A push while full SHALL be dropped silently, even if a pop occurs in the same cycle.

REQ-007 A simultaneous push and pop SHALL leave o_Fifo_Count unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH.

REQ-008 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- PARITY SHALL be skipped when PARITY=0.

REQ-009 In IDLE with the FIFO non-empty, the block SHALL:
- pop the head word into a shift register;
- set o_Tx_Active=1;
- enter START.
In IDLE, o_Tx_Serial SHALL be 1.

REQ-010 Latency: a word pushed into an empty FIFO in idle at cycle N SHALL drive o_Tx_Serial=0 from cycle N+2.

REQ-011 Bit timing:
- START SHALL drive 0 for CLKS_PER_BIT cycles.
- DATA SHALL drive DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles.
- PARITY SHALL drive ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles.
- STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.

REQ-012 Frame length SHALL be exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.

REQ-013 The bit counter SHALL be 32 bits wide and reset to 0 at every bit boundary. The bit index SHALL count 0..DATA_BITS-1.

REQ-014 On the last STOP cycle, o_Tx_Done SHALL pulse high for exactly one cycle, on the following cycle.

REQ-015 On the last STOP cycle, if the FIFO is non-empty, the block SHALL pop and go directly to START.
- There SHALL be no idle gap between frames.
- o_Tx_Active SHALL stay 1.
Otherwise the block SHALL go to IDLE with o_Tx_Active=0.

REQ-016 i_Tx_DV and i_Tx_Byte SHALL have no effect on a frame already in progress.

REQ-017 The block SHALL return to IDLE from any undefined state encoding.

Reset
REQ-018 While i_Rst_n=0 at a rising edge, the following SHALL hold on the next cycle:
- o_Tx_Serial=1, o_Tx_Done=0, o_Tx_Active=0;
- o_Fifo_Count=0, o_Tx_Ready=1;
- FSM=IDLE; counters and pointers cleared.

REQ-019 Reset asserted mid-frame SHALL:
- abort the frame;
- discard all queued words;
- produce no o_Tx_Done pulse.

REQ-020 i_Tx_DV asserted during reset SHALL be ignored.

Verification
REQ-021 A bench SHALL cover at least the following directed scenarios, with CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated:
- PARITY=0, push 0xA5 -> serial 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_Tx_Done pulses once, 40 cycles after the first 0 cycle.
- PARITY=1, push 0x07 -> parity bit 1, frame 44 cycles. PARITY=2, push 0x07 -> parity bit 0.
- FIFO_DEPTH=4, one frame active, 5 consecutive pushes -> 4 accepted. o_Tx_Ready=0 after the 4th. 5th word never transmitted. o_Fifo_Count peaks at 4.
- Push 0x55 and 0x0F back-to-back -> second START begins the cycle after the first STOP ends. o_Tx_Active held 1 throughout. Two o_Tx_Done pulses 40 cycles apart.
- Reset during data bit 3 -> o_Tx_Serial=1, o_Fifo_Count=0, o_Tx_Active=0 next cycle. No o_Tx_Done pulse.
- DATA_BITS=5, STOP_BITS=2, push 0x13 -> serial 0,1,1,0,0,1,1,1; frame 32 cycles.
